block_sprite_writer: RTL and testbench

- Fills the 2-bit-per-pixel block sprite memory that the block drawers read during the active display window.
- On a start request, generates a bevelled, solid or cleared block image in row-major order and issues one memory write per pixel.
- Writes occur only while the caller asserts blank_ok, i.e. when the drawers are outside their read window.
- Sits between game/palette control logic and the sprite RAM write port.

---
 rtl/block_sprite_writer.sv | 116 +++++++++++
 tb/tb_block_sprite_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_sprite_writer.sv
// Block sprite memory filler: walks the BLK_W x BLK_H sprite in row-major order
// and writes one 2-bit pixel per blank_ok cycle (clear, solid, bevel or highlight).
module block_sprite_writer #(
    parameter int unsigned BLK_W  = 78,
    parameter int unsigned BLK_H  = 53,
    parameter int unsigned BORDER = 3,
    parameter int unsigned AW     = 13
) (
    input  logic          vclk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    style,
    input  logic          blank_ok,
    output logic          busy,
    output logic          done,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [1:0]    wdata
);

    localparam int unsigned XW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int unsigned YW = (BLK_H > 1) ? $clog2(BLK_H) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(BLK_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(BLK_H - 1);
    localparam logic [XW-1:0] X_SHADOW = XW'(BLK_W - BORDER);
    localparam logic [YW-1:0] Y_SHADOW = YW'(BLK_H - BORDER);
    localparam logic [XW-1:0] X_HI     = XW'(BORDER);
    localparam logic [YW-1:0] Y_HI     = YW'(BORDER);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FINISH
    } state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [AW-1:0] addr;
    logic [1:0]    sty;
    logic [1:0]    code;

    // Shadow edges win over highlight edges, so the off-diagonal corners go dark.
    always_comb begin
        code = 2'b00;
        case (sty)
            2'b00: code = 2'b00;
            2'b01: code = 2'b01;
            2'b11: code = 2'b11;
            default: begin
                if (x >= X_SHADOW || y >= Y_SHADOW)
                    code = 2'b00;
                else if (x < X_HI || y < Y_HI)
                    code = 2'b11;
                else
                    code = 2'b01;
            end
        endcase
    end

    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= 2'b00;
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            sty   <= 2'b00;
        end else begin
            done <= 1'b0;
            we   <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    // busy is still high during the done cycle; a start there is dropped
                    if (start && !busy) begin
                        sty   <= style;
                        x     <= '0;
                        y     <= '0;
                        addr  <= '0;
                        busy  <= 1'b1;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (blank_ok) begin
                        we    <= 1'b1;
                        waddr <= addr;
                        wdata <= code;
                        addr  <= addr + 1'b1;
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST)
                                state <= FINISH;
                            else
                                y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_sprite_writer.sv
// Randomised bench for block_sprite_writer against a row-major pixel model.
module tb_block_sprite_writer;

    localparam int W = 78;
    localparam int H = 53;
    localparam int B = 3;
    localparam int N = W * H;

    logic        vclk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  style = 2'b00;
    logic        blank_ok = 1'b0;
    logic        busy, done, we;
    logic [12:0] waddr;
    logic [1:0]  wdata;

    logic        s_start = 1'b0;
    logic        s_blank_ok = 1'b0;
    logic        s_busy, s_done, s_we;
    logic [3:0]  s_waddr;
    logic [1:0]  s_wdata;

    always #5 vclk = ~vclk;

    block_sprite_writer dut (
        .vclk(vclk), .rst(rst), .start(start), .style(style), .blank_ok(blank_ok),
        .busy(busy), .done(done), .we(we), .waddr(waddr), .wdata(wdata)
    );

    block_sprite_writer #(.BLK_W(4), .BLK_H(3), .BORDER(1), .AW(4)) dut_small (
        .vclk(vclk), .rst(rst), .start(s_start), .style(2'b10), .blank_ok(s_blank_ok),
        .busy(s_busy), .done(s_done), .we(s_we), .waddr(s_waddr), .wdata(s_wdata)
    );

    int checks = 0;
    int errors = 0;

    int         wq_addr[$];
    logic [1:0] wq_data[$];
    int   ndone, first_we, last_we, blank_viol, done_cyc, hold_err;
    logic busy_at_start, we_at_start, busy_at_done, busy_after, timed_out;

    function automatic logic [1:0] model_code(logic [1:0] sty, int a, int w, int h, int b);
        int px, py;
        px = a % w;
        py = a / w;
        case (sty)
            2'b00: return 2'b00;
            2'b01: return 2'b01;
            2'b11: return 2'b11;
            default: begin
                if (px >= w - b || py >= h - b) return 2'b00;
                if (px < b || py < b) return 2'b11;
                return 2'b01;
            end
        endcase
    endfunction

    // mode 0: blank_ok high, 1: one on / three off, 2: random
    task automatic do_fill(input logic [1:0] sty, input int mode, input int restart_at, input int hold_low);
        logic bo;
        wq_addr.delete();
        wq_data.delete();
        ndone = 0; first_we = -1; last_we = -1; blank_viol = 0; done_cyc = -1; hold_err = 0;
        timed_out = 1'b1; busy_after = 1'b1; busy_at_done = 1'b0;
        style = sty;
        start = 1'b1;
        blank_ok = (hold_low == 0 && mode == 0);
        @(negedge vclk);
        start = 1'b0;
        busy_at_start = busy;
        we_at_start = we;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            if (cyc < hold_low) bo = 1'b0;
            else if (mode == 0) bo = 1'b1;
            else if (mode == 1) bo = ((cyc - hold_low) % 4 == 0);
            else bo = 1'($urandom_range(0, 1));
            blank_ok = bo;
            @(negedge vclk);
            start = 1'b0;
            if (we) begin
                if (!bo) blank_viol++;
                wq_addr.push_back(int'(waddr));
                wq_data.push_back(wdata);
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
            end
            if (cyc < hold_low && (!busy || we || waddr != 0)) hold_err++;
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    busy_at_done = busy;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            if (done_cyc >= 0 && cyc == done_cyc + 3) begin
                timed_out = 1'b0;
                break;
            end
            if (restart_at > 0 && we && (wq_addr.size() == restart_at || wq_addr.size() == N)) begin
                start = 1'b1;
                style = ~sty;
            end
        end
        blank_ok = 1'b0;
        style = sty;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge vclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
        checks++; if (waddr !== 13'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", waddr); end
        checks++; if (wdata !== 2'b00) begin errors++; $display("FAIL reset_wdata: got %b expected 00", wdata); end
        rst = 1'b0;
        @(negedge vclk);
    endtask

    task automatic test_hold_blank;
        do_fill(2'b01, 0, 0, 500);
        checks++; if (timed_out) begin errors++; $display("FAIL hold_timeout: got timeout expected done"); end
        checks++; if (hold_err !== 0) begin errors++; $display("FAIL hold_idle: got %0d bad cycles expected 0", hold_err); end
        checks++; if (first_we !== 500) begin errors++; $display("FAIL hold_first_we: got cycle %0d expected 500", first_we); end
        checks++; if (wq_addr.size() !== N) begin errors++; $display("FAIL hold_count: got %0d expected %0d", wq_addr.size(), N); end
        checks++; if (wq_addr.size() == 0 || wq_addr[0] !== 0) begin errors++; $display("FAIL hold_first_addr: got %0d expected 0", wq_addr.size() ? wq_addr[0] : -1); end
    endtask

    task automatic test_bevel;
        int bad, first_bad;
        do_fill(2'b10, 0, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL bevel_timeout: got timeout expected done"); end
        checks++; if (busy_at_start !== 1'b1 || we_at_start !== 1'b0) begin errors++; $display("FAIL bevel_start: got busy %b we %b expected 1 0", busy_at_start, we_at_start); end
        checks++; if (first_we !== 0) begin errors++; $display("FAIL bevel_first_we: got cycle %0d expected 0", first_we); end
        checks++; if (wq_addr.size() !== N || last_we - first_we + 1 !== N) begin errors++; $display("FAIL bevel_consecutive: got %0d writes over %0d cycles expected %0d", wq_addr.size(), last_we - first_we + 1, N); end
        bad = 0; first_bad = -1;
        foreach (wq_addr[i]) if (wq_addr[i] != i || wq_data[i] !== model_code(2'b10, i, W, H, B)) begin bad++; if (first_bad < 0) first_bad = i; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bevel_pixels: got %0d bad writes (first %0d) expected 0", bad, first_bad); end
        if (wq_data.size() == N) begin
            checks++; if (wq_data[0] !== 2'b11) begin errors++; $display("FAIL bevel_px0: got %b expected 11", wq_data[0]); end
            checks++; if (wq_data[77] !== 2'b00) begin errors++; $display("FAIL bevel_px77: got %b expected 00", wq_data[77]); end
            checks++; if (wq_data[240] !== 2'b01) begin errors++; $display("FAIL bevel_px240: got %b expected 01", wq_data[240]); end
            checks++; if (wq_data[4056] !== 2'b00) begin errors++; $display("FAIL bevel_px4056: got %b expected 00", wq_data[4056]); end
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL bevel_done_count: got %0d expected 1", ndone); end
        checks++; if (done_cyc !== last_we + 1) begin errors++; $display("FAIL bevel_done_time: got cycle %0d expected %0d", done_cyc, last_we + 1); end
        checks++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin errors++; $display("FAIL bevel_busy_end: got %b %b expected 1 0", busy_at_done, busy_after); end
    endtask

    task automatic test_throttled;
        int bad;
        do_fill(2'b01, 1, 0, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL throttle_timeout: got timeout expected done"); end
        checks++; if (wq_addr.size() !== N) begin errors++; $display("FAIL throttle_count: got %0d expected %0d", wq_addr.size(), N); end
        bad = 0;
        foreach (wq_addr[i]) if (wq_addr[i] != i || wq_data[i] !== 2'b01) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL throttle_pixels: got %0d bad writes expected 0", bad); end
        checks++; if (blank_viol !== 0) begin errors++; $display("FAIL throttle_we_blank: got %0d writes while blocked expected 0", blank_viol); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL throttle_done_count: got %0d expected 1", ndone); end
    endtask

    task automatic test_restart_ignored;
        int bad;
        do_fill(2'b10, 2, 100, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL restart_timeout: got timeout expected done"); end
        checks++; if (wq_addr.size() !== N) begin errors++; $display("FAIL restart_count: got %0d expected %0d", wq_addr.size(), N); end
        bad = 0;
        foreach (wq_addr[i]) if (wq_addr[i] != i || wq_data[i] !== model_code(2'b10, i, W, H, B)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL restart_pixels: got %0d bad writes expected 0", bad); end
        checks++; if (blank_viol !== 0) begin errors++; $display("FAIL restart_we_blank: got %0d expected 0", blank_viol); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", ndone); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL restart_busy_after: got %b expected 0", busy_after); end
    endtask

    task automatic test_random_styles;
        int bad;
        logic [1:0] sty;
        for (int r = 0; r < 2; r++) begin
            sty = 2'($urandom_range(0, 3));
            do_fill(sty, 2, 0, 0);
            bad = 0;
            foreach (wq_addr[i]) if (wq_addr[i] != i || wq_data[i] !== model_code(sty, i, W, H, B)) bad++;
            checks++; if (wq_addr.size() !== N || bad !== 0 || timed_out) begin errors++; $display("FAIL random_style%0d: got %0d writes %0d bad expected %0d writes 0 bad", sty, wq_addr.size(), bad, N); end
        end
    endtask

    task automatic test_reset_midfill;
        logic found;
        int bad, saw_done;
        found = 1'b0;
        style = 2'b10;
        start = 1'b1;
        blank_ok = 1'b1;
        @(negedge vclk);
        start = 1'b0;
        for (int c = 0; c < 6000 && !found; c++) begin
            @(negedge vclk);
            if (we && waddr == 13'd2000) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL midfill_reach: got no write at 2000 expected one"); end
        #2 rst = 1'b1;
        #1;
        checks++; if (we !== 1'b0 || busy !== 1'b0 || waddr !== 13'd0 || done !== 1'b0) begin errors++; $display("FAIL midfill_async: got we %b busy %b waddr %0d done %b expected 0 0 0 0", we, busy, waddr, done); end
        @(negedge vclk);
        rst = 1'b0;
        saw_done = 0;
        repeat (5) begin
            @(negedge vclk);
            if (done || we || busy) saw_done++;
        end
        checks++; if (saw_done !== 0) begin errors++; $display("FAIL midfill_quiet: got %0d active cycles expected 0", saw_done); end
        do_fill(2'b00, 0, 0, 0);
        bad = 0;
        foreach (wq_addr[i]) if (wq_addr[i] != i || wq_data[i] !== 2'b00) bad++;
        checks++; if (wq_addr.size() !== N || bad !== 0 || timed_out) begin errors++; $display("FAIL midfill_refill: got %0d writes %0d bad expected %0d writes 0 bad", wq_addr.size(), bad, N); end
    endtask

    task automatic test_small;
        logic [1:0] exp_small [12] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [1:0] got [$];
        int addr_bad, data_bad, sdone;
        addr_bad = 0; data_bad = 0; sdone = 0;
        s_start = 1'b1;
        s_blank_ok = 1'b1;
        @(negedge vclk);
        s_start = 1'b0;
        for (int c = 0; c < 100 && sdone == 0; c++) begin
            @(negedge vclk);
            if (s_we) begin
                if (int'(s_waddr) != got.size()) addr_bad++;
                got.push_back(s_wdata);
            end
            if (s_done) sdone++;
        end
        s_blank_ok = 1'b0;
        checks++; if (got.size() !== 12 || sdone !== 1) begin errors++; $display("FAIL small_count: got %0d writes %0d done expected 12 1", got.size(), sdone); end
        foreach (got[i]) if (i < 12 && (got[i] !== exp_small[i] || got[i] !== model_code(2'b10, i, 4, 3, 1))) data_bad++;
        checks++; if (data_bad !== 0 || addr_bad !== 0) begin errors++; $display("FAIL small_pixels: got %0d bad data %0d bad addr expected 0 0", data_bad, addr_bad); end
    endtask

    initial begin
        test_reset();
        test_hold_blank();
        test_bevel();
        test_throttled();
        test_restart_ignored();
        test_random_styles();
        test_reset_midfill();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
